// File: rtl/pacman_pkg.sv
// ============================================================================
// Module : pacman_pkg
// Brief  : Shared direction codes, motion states and flag helpers for maze sprites
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pacman_pkg;

  localparam logic [3:0] DIR_L    = 4'b1000;
  localparam logic [3:0] DIR_U    = 4'b0100;
  localparam logic [3:0] DIR_R    = 4'b0010;
  localparam logic [3:0] DIR_D    = 4'b0001;
  localparam logic [3:0] DIR_NONE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MOVING  = 2'd1,
    ST_BLOCKED = 2'd2
  } motion_state_t;

  function automatic logic dir_open(input logic [3:0] dir,
                                    input logic [2:0] f_l,
                                    input logic [2:0] f_u,
                                    input logic [2:0] f_r,
                                    input logic [2:0] f_d);
    logic r_open;
    r_open = 1'b0;
    case (dir)
      DIR_L:   r_open = |f_l;
      DIR_U:   r_open = |f_u;
      DIR_R:   r_open = |f_r;
      DIR_D:   r_open = |f_d;
      default: r_open = 1'b0;
    endcase
    return r_open;
  endfunction

  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/turn_buffer.sv
// ============================================================================
// Module : turn_buffer
// Brief  : Holds the latest one-hot turn request until it commits or times out
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module turn_buffer
  import pacman_pkg::*;
#(
  parameter int TURN_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_en,
  input  logic [3:0] btn,
  input  logic       commit,
  output logic [3:0] pend_dir,
  output logic       turn_pending
);

  localparam int                 c_CNT_W = $clog2(TURN_HOLD + 1);
  localparam logic [c_CNT_W-1:0] c_HOLD  = c_CNT_W'(TURN_HOLD);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [3:0]         r_pend_dir;
  logic [c_CNT_W-1:0] r_pend_cnt;
  logic               r_pending;
  logic               w_capture;

  assign w_capture = is_one_hot(btn);

  // A fresh request wins over a same-cycle commit of the older one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_dir <= DIR_NONE;
      r_pend_cnt <= '0;
      r_pending  <= 1'b0;
    end else if (w_capture) begin
      r_pend_dir <= btn;
      r_pend_cnt <= c_HOLD;
      r_pending  <= 1'b1;
    end else if (commit) begin
      r_pending  <= 1'b0;
    end else if (step_en && r_pending) begin
      r_pend_cnt <= r_pend_cnt - c_ONE;
      if (r_pend_cnt == c_ONE) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign pend_dir     = r_pend_dir;
  assign turn_pending = r_pending;

endmodule

`default_nettype wire

// File: rtl/sprite_motion_ctrl.sv
// ============================================================================
// Module : sprite_motion_ctrl
// Brief  : Maze sprite mover with buffered turns, tunnel wrap and blocked status
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sprite_motion_ctrl
  import pacman_pkg::*;
#(
  parameter int W         = 9,
  parameter int START_X   = 200,
  parameter int START_Y   = 230,
  parameter int VEL       = 1,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 447,
  parameter int WRAP_EN   = 1,
  parameter int TURN_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step_en,
  input  logic [3:0]   btn,
  input  logic [2:0]   flag_L,
  input  logic [2:0]   flag_U,
  input  logic [2:0]   flag_R,
  input  logic [2:0]   flag_D,
  output logic [W-1:0] p_x,
  output logic [W-1:0] p_y,
  output logic [3:0]   going_direction,
  output logic         moving,
  output logic         turn_pending
);

  localparam logic [W-1:0] c_VEL     = W'(VEL);
  localparam logic [W-1:0] c_START_X = W'(START_X);
  localparam logic [W-1:0] c_START_Y = W'(START_Y);
  localparam logic [W-1:0] c_L_LIMIT = W'(X_MIN + VEL);
  localparam logic [W-1:0] c_R_LIMIT = W'(X_MAX - VEL);

  motion_state_t r_state, w_state_nxt;
  logic [W-1:0]  r_x, r_y, w_x_nxt, w_y_nxt;
  logic [3:0]    r_dir, w_pend_dir;
  logic [W-1:0]  w_l_edge, w_r_edge;
  logic          w_pending, w_commit, w_dir_open, w_move;

  turn_buffer #(.TURN_HOLD(TURN_HOLD)) u_turn_buffer (
    .clk          (clk),
    .rst          (rst),
    .step_en      (step_en),
    .btn          (btn),
    .commit       (w_commit),
    .pend_dir     (w_pend_dir),
    .turn_pending (w_pending)
  );

  // Where an X move past the edge lands: opposite side (tunnel) or same side.
  generate
    if (WRAP_EN != 0) begin : g_wrap
      assign w_l_edge = W'(X_MAX);
      assign w_r_edge = W'(X_MIN);
    end else begin : g_sat
      assign w_l_edge = W'(X_MIN);
      assign w_r_edge = W'(X_MAX);
    end
  endgenerate

  assign w_commit   = w_pending && dir_open(w_pend_dir, flag_L, flag_U, flag_R, flag_D);
  assign w_dir_open = dir_open(r_dir, flag_L, flag_U, flag_R, flag_D);
  assign w_move     = step_en && (r_state != ST_IDLE) && w_dir_open;

  // Edge compare precedes the add so W-bit arithmetic never overflows.
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_move) begin
      case (r_dir)
        DIR_L:   w_x_nxt = (r_x < c_L_LIMIT) ? w_l_edge : r_x - c_VEL;
        DIR_R:   w_x_nxt = (r_x > c_R_LIMIT) ? w_r_edge : r_x + c_VEL;
        DIR_U:   w_y_nxt = r_y - c_VEL;
        DIR_D:   w_y_nxt = r_y + c_VEL;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_commit) w_state_nxt = ST_MOVING;
      ST_MOVING:  if (w_commit) w_state_nxt = ST_MOVING;
                  else if (step_en && !w_dir_open) w_state_nxt = ST_BLOCKED;
      ST_BLOCKED: if (w_commit || (step_en && w_dir_open)) w_state_nxt = ST_MOVING;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x   <= c_START_X;
      r_y   <= c_START_Y;
      r_dir <= DIR_NONE;
    end else begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
      if (w_commit) r_dir <= w_pend_dir;
    end
  end

  assign p_x             = r_x;
  assign p_y             = r_y;
  assign going_direction = r_dir;
  assign moving          = (r_state == ST_MOVING);
  assign turn_pending    = w_pending;

endmodule

`default_nettype wire
